uart_fifo_core: RTL and testbench

Full-duplex UART with runtime-selectable parity and stop-bit modes, a TX FIFO and an RX FIFO, and separate error flags. Parametrised in data width, baud timing and FIFO depth. Replaces the plain tx/rx pair as the host-side serial port. Both user sides use valid/ready streams.

---
 rtl/uart_fifo_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, runtime parity/stop-bit config and one-cycle error pulses.
// Define UART_LOOPBACK_EN to add loopback_i, which feeds the TX bit into the RX path and idles tx_o.
module uart_fifo_core #(
  parameter int N       = 8,
  parameter int PSCALER = 1,
  parameter int DIV     = 10,
  parameter int FIFO_AW = 4
) (
  input  logic               sysclk,
  input  logic               reset_n,
`ifdef UART_LOOPBACK_EN
  input  logic               loopback_i,
`endif
  input  logic               parity_en_i,
  input  logic               parity_odd_i,
  input  logic               stop2_i,
  input  logic               tx_valid_i,
  input  logic [N-1:0]       tx_data_i,
  output logic               tx_ready_o,
  output logic               tx_o,
  output logic               tx_busy_o,
  output logic [FIFO_AW:0]   tx_level_o,
  input  logic               rx_i,
  output logic               rx_valid_o,
  output logic [N-1:0]       rx_data_o,
  input  logic               rx_ready_i,
  output logic [FIFO_AW:0]   rx_level_o,
  output logic               rx_parity_err_o,
  output logic               rx_frame_err_o,
  output logic               rx_overrun_o
);
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int BIT_T     = PSCALER * DIV;
  localparam int HALF_LOAD = BIT_T - BIT_T / 2;
  localparam logic [15:0] PRE_LAST = 16'(PSCALER - 1);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] HALF_PRE = 16'(HALF_LOAD % PSCALER);
  localparam logic [15:0] HALF_DIV = 16'(HALF_LOAD / PSCALER);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(N - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  logic [N-1:0]       txf_mem_q [DEPTH];
  logic [N-1:0]       rxf_mem_q [DEPTH];
  logic [FIFO_AW-1:0] txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
  logic [FIFO_AW-1:0] rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
  logic [FIFO_AW:0]   txf_lvl_q, txf_lvl_d, rxf_lvl_q, rxf_lvl_d;
  logic               txf_push, txf_pop, txf_nonempty, rxf_push, rxf_pop, rxf_ready;

  logic [15:0] tx_pre_q, tx_pre_d, tx_div_q, tx_div_d;
  logic [15:0] rx_pre_q, rx_pre_d, rx_div_q, rx_div_d;
  logic        tx_tick, rx_tick, tx_restart, rx_restart;

  tx_state_e   tx_state_q, tx_state_d;
  logic [N-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
  logic        tx_stop2_q, tx_stop2_d, tx_bit_q, tx_bit_d, tx_load;

  rx_state_e   rx_state_q, rx_state_d;
  logic [N-1:0] rx_shift_q, rx_shift_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic        rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic        rx_par_bad_q, rx_par_bad_d;
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q, rx_src;
  logic        rx_push, rx_par_err, rx_frame_err;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback_i ? tx_bit_q : rx_i;
  assign tx_o   = loopback_i ? 1'b1 : tx_bit_q;
`else
  assign rx_src = rx_i;
  assign tx_o   = tx_bit_q;
`endif

  assign tx_ready_o   = (txf_lvl_q != FULL);
  assign txf_nonempty = (txf_lvl_q != '0);
  assign txf_push     = tx_valid_i && tx_ready_o;
  assign txf_pop      = tx_load;
  assign tx_level_o   = txf_lvl_q;
  assign tx_busy_o    = (tx_state_q != TX_IDLE) || txf_nonempty;

  assign rxf_ready       = (rxf_lvl_q != FULL);
  assign rx_valid_o      = (rxf_lvl_q != '0);
  assign rxf_pop         = rx_valid_o && rx_ready_i;
  assign rxf_push        = rx_push && rxf_ready;
  assign rx_data_o       = rx_valid_o ? rxf_mem_q[rxf_rd_q] : '0;
  assign rx_level_o      = rxf_lvl_q;
  assign rx_parity_err_o = rx_par_err;
  assign rx_frame_err_o  = rx_frame_err;
  assign rx_overrun_o    = rx_push && !rxf_ready;

  assign tx_tick = (tx_pre_q == PRE_LAST) && (tx_div_q == DIV_LAST);
  assign rx_tick = (rx_pre_q == PRE_LAST) && (rx_div_q == DIV_LAST);

  always_comb begin
    txf_wr_d  = txf_wr_q + FIFO_AW'(txf_push);
    txf_rd_d  = txf_rd_q + FIFO_AW'(txf_pop);
    txf_lvl_d = txf_lvl_q + (FIFO_AW + 1)'(txf_push) - (FIFO_AW + 1)'(txf_pop);
    rxf_wr_d  = rxf_wr_q + FIFO_AW'(rxf_push);
    rxf_rd_d  = rxf_rd_q + FIFO_AW'(rxf_pop);
    rxf_lvl_d = rxf_lvl_q + (FIFO_AW + 1)'(rxf_push) - (FIFO_AW + 1)'(rxf_pop);
  end

  // Prescaler feeds the divider; RX restarts half a bit in so every sample lands mid-bit.
  always_comb begin
    tx_pre_d = (tx_pre_q == PRE_LAST) ? '0 : tx_pre_q + 16'd1;
    tx_div_d = tx_div_q;
    if (tx_pre_q == PRE_LAST) tx_div_d = (tx_div_q == DIV_LAST) ? '0 : tx_div_q + 16'd1;
    if (tx_restart) begin
      tx_pre_d = '0;
      tx_div_d = '0;
    end
    rx_pre_d = (rx_pre_q == PRE_LAST) ? '0 : rx_pre_q + 16'd1;
    rx_div_d = rx_div_q;
    if (rx_pre_q == PRE_LAST) rx_div_d = (rx_div_q == DIV_LAST) ? '0 : rx_div_q + 16'd1;
    if (rx_restart) begin
      rx_pre_d = HALF_PRE;
      rx_div_d = HALF_DIV;
    end
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_stop2_d   = tx_stop2_q;
    tx_load      = 1'b0;
    case (tx_state_q)
      TX_IDLE:   if (txf_nonempty) tx_load = 1'b1;
      TX_START:  if (tx_tick) begin
                   tx_state_d = TX_DATA;
                   tx_cnt_d   = '0;
                 end
      TX_DATA:   if (tx_tick) begin
                   tx_shift_d = tx_shift_q >> 1;
                   if (tx_cnt_q == LAST_BIT) begin
                     tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
                     tx_cnt_d   = '0;
                   end else begin
                     tx_cnt_d = tx_cnt_q + 4'd1;
                   end
                 end
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_tick) begin
                   if (tx_stop2_q && tx_cnt_q == 4'd0) tx_cnt_d = 4'd1;
                   else if (txf_nonempty) tx_load = 1'b1;
                   else tx_state_d = TX_IDLE;
                 end
      default:   tx_state_d = TX_IDLE;
    endcase
    // A new frame snapshots data and line config so mid-frame config changes cannot corrupt it.
    if (tx_load) begin
      tx_state_d   = TX_START;
      tx_shift_d   = txf_mem_q[txf_rd_q];
      tx_cnt_d     = '0;
      tx_par_en_d  = parity_en_i;
      tx_par_bit_d = (^txf_mem_q[txf_rd_q]) ^ parity_odd_i;
      tx_stop2_d   = stop2_i;
    end
    tx_restart = tx_load;
    case (tx_state_q)
      TX_START:  tx_bit_d = 1'b0;
      TX_DATA:   tx_bit_d = tx_shift_q[0];
      TX_PARITY: tx_bit_d = tx_par_bit_q;
      default:   tx_bit_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_cnt_d     = rx_cnt_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_restart   = 1'b0;
    rx_push      = 1'b0;
    rx_par_err   = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state_q)
      RX_IDLE:      if (rx_prev_q && !rx_sync2_q) begin
                      rx_restart   = 1'b1;
                      rx_state_d   = RX_START;
                      rx_par_en_d  = parity_en_i;
                      rx_par_odd_d = parity_odd_i;
                      rx_par_bad_d = 1'b0;
                    end
      RX_START:     if (rx_tick) begin
                      rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                      rx_cnt_d   = '0;
                    end
      RX_DATA:      if (rx_tick) begin
                      rx_shift_d = {rx_sync2_q, rx_shift_q[N-1:1]};
                      if (rx_cnt_q == LAST_BIT) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                      else rx_cnt_d = rx_cnt_q + 4'd1;
                    end
      RX_PARITY:    if (rx_tick) begin
                      rx_par_bad_d = rx_sync2_q ^ (^rx_shift_q) ^ rx_par_odd_q;
                      rx_state_d   = RX_STOP;
                    end
      RX_STOP:      if (rx_tick) begin
                      if (!rx_sync2_q) begin
                        rx_frame_err = 1'b1;
                        rx_state_d   = RX_WAIT_HIGH;
                      end else begin
                        rx_push    = 1'b1;
                        rx_par_err = rx_par_bad_q;
                        rx_state_d = RX_IDLE;
                      end
                    end
      RX_WAIT_HIGH: if (rx_sync2_q) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (txf_push) txf_mem_q[txf_wr_q] <= tx_data_i;
    if (rxf_push) rxf_mem_q[rxf_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      txf_wr_q <= '0; txf_rd_q <= '0; txf_lvl_q <= '0;
      rxf_wr_q <= '0; rxf_rd_q <= '0; rxf_lvl_q <= '0;
      tx_pre_q <= '0; tx_div_q <= '0; rx_pre_q <= '0; rx_div_q <= '0;
      tx_state_q <= TX_IDLE; tx_shift_q <= '0; tx_cnt_q <= '0;
      tx_par_en_q <= 1'b0; tx_par_bit_q <= 1'b0; tx_stop2_q <= 1'b0; tx_bit_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_shift_q <= '0; rx_cnt_q <= '0;
      rx_par_en_q <= 1'b0; rx_par_odd_q <= 1'b0; rx_par_bad_q <= 1'b0;
      rx_sync1_q <= 1'b1; rx_sync2_q <= 1'b1; rx_prev_q <= 1'b1;
    end else begin
      txf_wr_q <= txf_wr_d; txf_rd_q <= txf_rd_d; txf_lvl_q <= txf_lvl_d;
      rxf_wr_q <= rxf_wr_d; rxf_rd_q <= rxf_rd_d; rxf_lvl_q <= rxf_lvl_d;
      tx_pre_q <= tx_pre_d; tx_div_q <= tx_div_d; rx_pre_q <= rx_pre_d; rx_div_q <= rx_div_d;
      tx_state_q <= tx_state_d; tx_shift_q <= tx_shift_d; tx_cnt_q <= tx_cnt_d;
      tx_par_en_q <= tx_par_en_d; tx_par_bit_q <= tx_par_bit_d; tx_stop2_q <= tx_stop2_d;
      tx_bit_q <= tx_bit_d;
      rx_state_q <= rx_state_d; rx_shift_q <= rx_shift_d; rx_cnt_q <= rx_cnt_d;
      rx_par_en_q <= rx_par_en_d; rx_par_odd_q <= rx_par_odd_d; rx_par_bad_q <= rx_par_bad_d;
      rx_sync1_q <= rx_src; rx_sync2_q <= rx_sync1_q; rx_prev_q <= rx_sync2_q;
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: directed and randomized TX/RX frames against a
// bit-list line model and a queue model of the RX FIFO.
module tb_uart_fifo_core;
  localparam int N     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BIT_T = 10;

  typedef logic [N-1:0] byte_q_t [$];

  logic          sysclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          parity_en_i = 1'b0, parity_odd_i = 1'b0, stop2_i = 1'b0;
  logic          tx_valid_i = 1'b0;
  logic [N-1:0]  tx_data_i = '0;
  logic          tx_ready_o, tx_o, tx_busy_o;
  logic [AW:0]   tx_level_o, rx_level_o;
  logic          rx_i = 1'b1;
  logic          rx_valid_o, rx_ready_i = 1'b0;
  logic [N-1:0]  rx_data_o;
  logic          rx_parity_err_o, rx_frame_err_o, rx_overrun_o;

  int checkCount = 0, passCount = 0;
  int parErrSeen = 0, frameErrSeen = 0, overrunSeen = 0;
  int parErrExp = 0, frameErrExp = 0, overrunExp = 0;
  logic [N-1:0] rxModel [$];

  uart_fifo_core #(.N(N), .PSCALER(1), .DIV(BIT_T), .FIFO_AW(AW)) dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .tx_o(tx_o), .tx_busy_o(tx_busy_o), .tx_level_o(tx_level_o),
    .rx_i(rx_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .rx_level_o(rx_level_o), .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o(rx_frame_err_o), .rx_overrun_o(rx_overrun_o)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (rx_parity_err_o) parErrSeen++;
    if (rx_frame_err_o) frameErrSeen++;
    if (rx_overrun_o) overrunSeen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Push a burst and compare the serial line against the expected bit list, one bit per period.
  task automatic applyTxBurst(input byte_q_t bytes, input logic parEn, input logic odd, input logic st2);
    bit expBits [$];
    int nb, total, last;
    foreach (bytes[i]) begin
      expBits.push_back(1'b0);
      for (int b = 0; b < N; b++) expBits.push_back(bytes[i][b]);
      if (parEn) expBits.push_back((^bytes[i]) ^ odd);
      expBits.push_back(1'b1);
      if (st2) expBits.push_back(1'b1);
    end
    nb = bytes.size();
    total = expBits.size();
    last = 2 + total * BIT_T;
    parity_en_i = parEn; parity_odd_i = odd; stop2_i = st2;
    tx_valid_i = 1'b1; tx_data_i = bytes[0];
    for (int c = 0; c <= last; c++) begin
      @(negedge sysclk);
      if (c < 2) checkOutput("tx_idle_before_start", 32'(tx_o), 32'd1);
      else if (c == 2) checkOutput("tx_start_fall", 32'(tx_o), 32'd0);
      else if (c < last && (c - 2) % BIT_T == BIT_T / 2) begin
        checkOutput("tx_bit", 32'(tx_o), 32'(expBits[(c - 2) / BIT_T]));
        if (c == last - BIT_T + BIT_T / 2) checkOutput("tx_busy_in_frame", 32'(tx_busy_o), 32'd1);
      end else if (c == last) begin
        checkOutput("tx_busy_after_burst", 32'(tx_busy_o), 32'd0);
        checkOutput("tx_line_idle", 32'(tx_o), 32'd1);
        checkOutput("tx_level_empty", 32'(tx_level_o), 32'd0);
      end
      tx_valid_i = (c + 1 < nb);
      if (c + 1 < nb) tx_data_i = bytes[c + 1];
    end
  endtask

  // Drive one RX frame on rx_i and record what the receiver should do with it.
  task automatic applyRxFrame(input logic [N-1:0] d, input logic parEn, input logic odd,
                              input logic badPar, input logic badStop);
    bit bits [$];
    parity_en_i = parEn; parity_odd_i = odd;
    bits.push_back(1'b0);
    for (int b = 0; b < N; b++) bits.push_back(d[b]);
    if (parEn) bits.push_back((^d) ^ odd ^ badPar);
    bits.push_back(!badStop);
    foreach (bits[i]) begin
      rx_i = bits[i];
      repeat (BIT_T) @(negedge sysclk);
    end
    if (!badStop) rx_i = 1'b1;
    if (badStop) frameErrExp++;
    else begin
      if (parEn && badPar) parErrExp++;
      if (rxModel.size() == DEPTH) overrunExp++;
      else rxModel.push_back(d);
    end
  endtask

  task automatic applyRxPop(input int count);
    for (int k = 0; k < count; k++) begin
      if (rxModel.size() == 0) break;
      checkOutput("rx_valid", 32'(rx_valid_o), 32'd1);
      checkOutput("rx_data", 32'(rx_data_o), 32'(rxModel[0]));
      rx_ready_i = 1'b1;
      @(negedge sysclk);
      rx_ready_i = 1'b0;
      void'(rxModel.pop_front());
      checkOutput("rx_level_after_pop", 32'(rx_level_o), 32'(rxModel.size()));
    end
  endtask

  task automatic checkErrCounts(input string tag);
    checkOutput({tag, "_parity_err_count"}, 32'(parErrSeen), 32'(parErrExp));
    checkOutput({tag, "_frame_err_count"}, 32'(frameErrSeen), 32'(frameErrExp));
    checkOutput({tag, "_overrun_count"}, 32'(overrunSeen), 32'(overrunExp));
  endtask

  initial begin
    byte_q_t q;
    logic [N-1:0] d;
    logic pe, od, bp;

    repeat (3) @(negedge sysclk);
    checkOutput("reset_tx_o", 32'(tx_o), 32'd1);
    checkOutput("reset_tx_ready", 32'(tx_ready_o), 32'd1);
    checkOutput("reset_tx_busy", 32'(tx_busy_o), 32'd0);
    checkOutput("reset_rx_valid", 32'(rx_valid_o), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data_o), 32'd0);
    checkOutput("reset_tx_level", 32'(tx_level_o), 32'd0);
    checkOutput("reset_rx_level", 32'(rx_level_o), 32'd0);
    checkOutput("reset_err_pulses", 32'({rx_parity_err_o, rx_frame_err_o, rx_overrun_o}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge sysclk);

    $display("[TB] TX single frame 0xA5, no parity, 1 stop");
    q.delete(); q.push_back(8'hA5);
    applyTxBurst(q, 1'b0, 1'b0, 1'b0);

    $display("[TB] TX back-to-back 0x3C 0xFF 0x00, even parity, 2 stops");
    q.delete(); q.push_back(8'h3C); q.push_back(8'hFF); q.push_back(8'h00);
    applyTxBurst(q, 1'b1, 1'b0, 1'b1);

    for (int t = 0; t < 3; t++) begin
      q.delete();
      for (int j = 0; j < $urandom_range(1, 3); j++) q.push_back(8'($urandom));
      applyTxBurst(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge sysclk);
    end

    $display("[TB] RX 0x5A with odd parity and a wrong parity bit");
    applyRxFrame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge sysclk);
    checkErrCounts("parity_case");
    checkOutput("rx_data_parity_case", 32'(rx_data_o), 32'h5A);
    checkOutput("rx_level_parity_case", 32'(rx_level_o), 32'd1);
    applyRxPop(1);

    $display("[TB] RX frame error followed by line held low");
    applyRxFrame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (30) @(negedge sysclk);
    rx_i = 1'b1;
    repeat (5) @(negedge sysclk);
    checkErrCounts("frame_case");
    checkOutput("rx_level_frame_case", 32'(rx_level_o), 32'd0);
    applyRxFrame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge sysclk);
    checkOutput("rx_level_after_recovery", 32'(rx_level_o), 32'd1);
    applyRxPop(1);

    $display("[TB] RX overrun: 17 frames into a 16-deep FIFO");
    for (int f = 0; f < DEPTH + 1; f++) applyRxFrame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge sysclk);
    checkOutput("rx_level_full", 32'(rx_level_o), 32'd16);
    checkOutput("rx_ready_blocked_level", 32'(rx_level_o), 32'(rxModel.size()));
    checkErrCounts("overrun_case");
    applyRxPop(DEPTH);
    checkOutput("rx_valid_drained", 32'(rx_valid_o), 32'd0);

    $display("[TB] RX 3-cycle glitch");
    rx_i = 1'b0;
    repeat (3) @(negedge sysclk);
    rx_i = 1'b1;
    repeat (30) @(negedge sysclk);
    checkErrCounts("glitch_case");
    checkOutput("rx_level_glitch", 32'(rx_level_o), 32'd0);

    $display("[TB] RX randomized frames");
    for (int f = 0; f < 10; f++) begin
      d = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      od = 1'($urandom_range(0, 1));
      bp = pe && ($urandom_range(0, 3) == 0);
      applyRxFrame(d, pe, od, bp, 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge sysclk);
      checkOutput("rx_level_random", 32'(rx_level_o), 32'(rxModel.size()));
      if ($urandom_range(0, 2) == 0) applyRxPop(1);
    end
    applyRxPop(DEPTH);
    checkErrCounts("random_case");

    $display("[TB] reset in the middle of a TX frame");
    tx_valid_i = 1'b1; tx_data_i = 8'h81; parity_en_i = 1'b0; stop2_i = 1'b0;
    @(negedge sysclk); tx_data_i = 8'h42;
    @(negedge sysclk); tx_data_i = 8'h24;
    @(negedge sysclk); tx_valid_i = 1'b0;
    repeat (30) @(negedge sysclk);
    checkOutput("tx_level_mid_frame", 32'(tx_level_o), 32'd2);
    checkOutput("tx_busy_mid_frame", 32'(tx_busy_o), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_tx_o", 32'(tx_o), 32'd1);
    checkOutput("reset_mid_tx_level", 32'(tx_level_o), 32'd0);
    checkOutput("reset_mid_tx_busy", 32'(tx_busy_o), 32'd0);
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (3) @(negedge sysclk);
    checkOutput("after_reset_tx_o", 32'(tx_o), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
